tdm_scan_mux: RTL and testbench
===============================

TDM_SCAN_MUX -- requirements
Module: tdm_scan_mux

Interface
REQ-001 Parameter CHANNELS, default 8: number of input channels; legal range 2..64.
REQ-002 Parameter WIDTH, default 1: bit width of each channel; legal range 1..32.
REQ-003 Parameter DWELL, default 1: clock cycles spent on each channel in auto-scan mode; legal range 1..256.
REQ-004 Derived SEL_W = clog2(CHANNELS), not user-set.
REQ-005 Clocking: one clock; reset is synchronous and active-high.
REQ-006 clk  input  1  sole clock; all state updates on rising edge.
REQ-007 rst  input  1  synchronous, active-high reset.
REQ-008 D  input  CHANNELS*WIDTH  channel data; channel k occupies bits [k*WIDTH +: WIDTH].
REQ-009 S  input  SEL_W  manual channel select.
REQ-010 mode  input  1  0 = manual select, 1 = auto-scan.
REQ-011 en  input  1  advance/sample enable.
REQ-012 Y  output  WIDTH  registered selected data.
REQ-013 ch  output  SEL_W  index of the channel currently on Y.
REQ-014 valid  output  1  Y/ch hold a fresh sample this cycle.
REQ-015 wrap  output  1  one-cycle pulse marking the final sample of channel CHANNELS-1 in auto-scan.

Function
REQ-016 Internal state: scan pointer ptr (SEL_W bits), dwell counter dcnt (clog2(DWELL+1) bits), registered outputs.
REQ-017 Latency: exactly one cycle; a sample taken at edge t appears on Y/ch/valid after edge t+1.
REQ-018 Auto mode, en=1: Y <= D[ptr], ch <= ptr, valid <= 1.
REQ-019 Auto mode, en=1: if dcnt == DWELL-1, dcnt <= 0 and ptr advances; otherwise dcnt increments.
REQ-020 Pointer advance: ptr <= ptr+1, except ptr == CHANNELS-1 wraps to 0 (no channel index >= CHANNELS ever visited, including non-power-of-2 CHANNELS).
REQ-021 wrap <= 1 in the same update that advances ptr from CHANNELS-1 to 0; else wrap <= 0.
REQ-022 Manual mode, en=1, S < CHANNELS: Y <= D[S], ch <= S, valid <= 1, wrap <= 0.
REQ-023 Manual mode, en=1, S >= CHANNELS: Y <= 0, ch <= S, valid <= 0, wrap <= 0.
REQ-024 Manual mode forces ptr <= 0 and dcnt <= 0 every cycle.
REQ-025 Manual-to-auto switch: scanning starts at channel 0 with full dwell on the first auto cycle.
REQ-026 Auto-to-manual switch: takes effect on the same edge; partial dwell discarded.
REQ-027 en=0 (either mode): ptr, dcnt, Y, ch held; valid <= 0, wrap <= 0.
REQ-028 Re-asserting en resumes auto scan at the held ptr/dcnt with no skipped or repeated sample.
REQ-029 D and S changes are visible only through the next enabled sample; no combinational path from inputs to outputs.

Reset
REQ-030 rst=1 at an edge forces Y=0, ch=0, valid=0, wrap=0, ptr=0, dcnt=0; it overrides en, mode and all other inputs.
REQ-031 Reset mid-dwell or mid-scan discards progress; the first sample after rst deasserts is channel 0 with full dwell.
REQ-032 Outputs are defined from the first edge with rst=1; no output depends on power-up state after that edge.

Verification
REQ-033 CHANNELS=8, WIDTH=1, DWELL=2, mode=1, en=1 from cycle 0, D=8'b0000_0100 -> Y=1 after edges 5 and 6 only, within each 16-cycle scan; ch steps 0,0,1,1,...,7,7; wrap=1 only with the cycle-16 sample.
REQ-034 Same config, mode=0, S cycles 0..7 with D=8'hA5 -> Y after each edge equals D[S] from the previous edge (1,0,1,0,0,1,0,1); valid=1 throughout.
REQ-035 CHANNELS=6, WIDTH=4, DWELL=1, auto -> ch sequence 0..5,0; wrap once per 6 cycles; S=7 in manual -> Y=0, valid=0.
REQ-036 Auto scan, en deasserted for 3 cycles while ptr=3, dcnt=0 -> Y/ch frozen at channel 2 sample, valid=0; on re-enable next sample is channel 3, then scan continues normally.
REQ-037 rst pulsed one cycle while ptr=5 mid-dwell, en=1, mode=1 -> all outputs 0 after the reset edge; next sample ch=0, then full DWELL on channel 0.
REQ-038 Auto scan at ptr=4, mode toggled to 0 (S=1) for one cycle then back to 1 -> one manual sample of channel 1, then scan restarts at channel 0.

Source files
------------

// File: rtl/tdm_scan_mux_if.sv
// Channel bus for tdm_scan_mux: data/select/control in, sampled data out.
// master drives D/S/mode/en; slave (the mux) returns Y/ch/valid/wrap.
interface tdm_scan_mux_if #(
    parameter int CHANNELS = 8,
    parameter int WIDTH    = 1
);
    localparam int SEL_W = $clog2(CHANNELS);

    logic [CHANNELS*WIDTH-1:0] D;
    logic [SEL_W-1:0]          S;
    logic                      mode;
    logic                      en;
    logic [WIDTH-1:0]          Y;
    logic [SEL_W-1:0]          ch;
    logic                      valid;
    logic                      wrap;

    modport master (
        output D, S, mode, en,
        input  Y, ch, valid, wrap
    );

    modport slave (
        input  D, S, mode, en,
        output Y, ch, valid, wrap
    );
endinterface

// File: rtl/tdm_scan_mux.sv
// Time-division scan multiplexer: auto-scans channels with a per-channel
// dwell, or samples a manually selected channel; one-cycle registered output.
module tdm_scan_mux #(
    parameter int CHANNELS = 8,
    parameter int WIDTH    = 1,
    parameter int DWELL    = 1
) (
    input logic          clk,
    input logic          rst,
    tdm_scan_mux_if.slave bus
);
    localparam int SEL_W  = $clog2(CHANNELS);
    localparam int DCNT_W = $clog2(DWELL + 1);

    localparam logic [SEL_W-1:0]  PTR_LAST  = SEL_W'(CHANNELS - 1);
    localparam logic [DCNT_W-1:0] DCNT_LAST = DCNT_W'(DWELL - 1);
    localparam logic [SEL_W:0]    NCH       = (SEL_W + 1)'(CHANNELS);

    logic [SEL_W-1:0]  ptr_q, ptr_d;
    logic [DCNT_W-1:0] dcnt_q, dcnt_d;
    logic [WIDTH-1:0]  y_q, y_d;
    logic [SEL_W-1:0]  ch_q, ch_d;
    logic              valid_q, valid_d;
    logic              wrap_q, wrap_d;

    logic [WIDTH-1:0]  auto_data;
    logic [WIDTH-1:0]  man_data;
    logic              s_in_range;

    // Loop mux never indexes past CHANNELS, so out-of-range S reads zero.
    always_comb begin
        auto_data = '0;
        man_data  = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            if (ptr_q == SEL_W'(k)) auto_data = bus.D[k*WIDTH +: WIDTH];
            if (bus.S == SEL_W'(k)) man_data  = bus.D[k*WIDTH +: WIDTH];
        end
    end

    assign s_in_range = ({1'b0, bus.S} < NCH);

    always_comb begin
        ptr_d   = ptr_q;
        dcnt_d  = dcnt_q;
        y_d     = y_q;
        ch_d    = ch_q;
        valid_d = 1'b0;
        wrap_d  = 1'b0;
        if (!bus.mode) begin
            // Manual mode always parks the scanner so auto restarts cleanly.
            ptr_d  = '0;
            dcnt_d = '0;
            if (bus.en) begin
                ch_d    = bus.S;
                y_d     = s_in_range ? man_data : '0;
                valid_d = s_in_range;
            end
        end else if (bus.en) begin
            y_d     = auto_data;
            ch_d    = ptr_q;
            valid_d = 1'b1;
            if (dcnt_q == DCNT_LAST) begin
                dcnt_d = '0;
                if (ptr_q == PTR_LAST) begin
                    ptr_d  = '0;
                    wrap_d = 1'b1;
                end else begin
                    ptr_d = ptr_q + 1'b1;
                end
            end else begin
                dcnt_d = dcnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q   <= '0;
            dcnt_q  <= '0;
            y_q     <= '0;
            ch_q    <= '0;
            valid_q <= 1'b0;
            wrap_q  <= 1'b0;
        end else begin
            ptr_q   <= ptr_d;
            dcnt_q  <= dcnt_d;
            y_q     <= y_d;
            ch_q    <= ch_d;
            valid_q <= valid_d;
            wrap_q  <= wrap_d;
        end
    end

    assign bus.Y     = y_q;
    assign bus.ch    = ch_q;
    assign bus.valid = valid_q;
    assign bus.wrap  = wrap_q;
endmodule

// File: tb/tb_tdm_scan_mux.sv
// Scoreboard bench for tdm_scan_mux: two configurations (8x1 dwell 2,
// 6x4 dwell 1) share control stimulus and are checked against a sample-count model.
module tb_tdm_scan_mux;
    logic clk;
    logic rst;

    tdm_scan_mux_if #(.CHANNELS(8), .WIDTH(1)) ifa ();
    tdm_scan_mux_if #(.CHANNELS(6), .WIDTH(4)) ifb ();

    tdm_scan_mux #(.CHANNELS(8), .WIDTH(1), .DWELL(2)) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (ifa.slave)
    );

    tdm_scan_mux #(.CHANNELS(6), .WIDTH(4), .DWELL(1)) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (ifb.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int y;
        int ch;
        bit valid;
        bit wrap;
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];
    exp_t mexp[2];
    int   mpos[2];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s act=%0d exp=%0d", name, act, exp);
        end
    endtask

    // Model counts auto samples since the last restart; channel and wrap
    // fall out of that count by division, independent of any pointer logic.
    task automatic model_step(int i, int nch, int w, int dw, bit r, bit m,
                              bit e, int s, logic [31:0] d);
        int c;
        int mask;
        mask = (1 << w) - 1;
        if (r) begin
            mpos[i]       = 0;
            mexp[i].y     = 0;
            mexp[i].ch    = 0;
            mexp[i].valid = 0;
            mexp[i].wrap  = 0;
        end else if (!m) begin
            mpos[i]       = 0;
            mexp[i].wrap  = 0;
            mexp[i].valid = 0;
            if (e) begin
                mexp[i].ch = s;
                if (s < nch) begin
                    mexp[i].y     = int'(d >> (s * w)) & mask;
                    mexp[i].valid = 1;
                end else begin
                    mexp[i].y = 0;
                end
            end
        end else if (!e) begin
            mexp[i].valid = 0;
            mexp[i].wrap  = 0;
        end else begin
            c             = (mpos[i] / dw) % nch;
            mexp[i].y     = int'(d >> (c * w)) & mask;
            mexp[i].ch    = c;
            mexp[i].valid = 1;
            mexp[i].wrap  = (mpos[i] % (dw * nch)) == (dw * nch - 1);
            mpos[i]++;
        end
    endtask

    task automatic cyc(bit r, bit m, bit e, int s,
                       logic [31:0] da, logic [31:0] db);
        @(negedge clk);
        rst      = r;
        ifa.mode = m;
        ifb.mode = m;
        ifa.en   = e;
        ifb.en   = e;
        ifa.S    = 3'(s);
        ifb.S    = 3'(s);
        ifa.D    = da[7:0];
        ifb.D    = db[23:0];
        model_step(0, 8, 1, 2, r, m, e, s, 32'(ifa.D));
        qa.push_back(mexp[0]);
        model_step(1, 6, 4, 1, r, m, e, s, 32'(ifb.D));
        qb.push_back(mexp[1]);
    endtask

    initial begin
        exp_t ea;
        exp_t eb;
        forever begin
            @(posedge clk);
            #1;
            if (qa.size() > 0) begin
                ea = qa.pop_front();
                chk("a_y",     int'(ifa.Y),     ea.y);
                chk("a_ch",    int'(ifa.ch),    ea.ch);
                chk("a_valid", int'(ifa.valid), int'(ea.valid));
                chk("a_wrap",  int'(ifa.wrap),  int'(ea.wrap));
            end
            if (qb.size() > 0) begin
                eb = qb.pop_front();
                chk("b_y",     int'(ifb.Y),     eb.y);
                chk("b_ch",    int'(ifb.ch),    eb.ch);
                chk("b_valid", int'(ifb.valid), int'(eb.valid));
                chk("b_wrap",  int'(ifb.wrap),  int'(eb.wrap));
            end
        end
    end

    initial begin
        logic [31:0] rb;
        rst      = 1'b1;
        ifa.mode = 1'b0;
        ifb.mode = 1'b0;
        ifa.en   = 1'b0;
        ifb.en   = 1'b0;
        ifa.S    = '0;
        ifb.S    = '0;
        ifa.D    = '0;
        ifb.D    = '0;

        cyc(1, 1, 1, 0, 32'hff, 32'hffffff);
        cyc(1, 0, 1, 3, 32'h5a, 32'h123456);

        // Auto scan, single hot channel 2, over two full scans.
        for (int i = 0; i < 34; i++)
            cyc(0, 1, 1, 0, 32'h04, 32'h654321);

        // Manual sweep of every select value, including out-of-range for B.
        for (int i = 0; i < 16; i++)
            cyc(0, 0, 1, i % 8, 32'hA5, 32'h9abcde);

        // Enable gap at A ptr=3 dcnt=0.
        cyc(1, 1, 1, 0, 32'h0f, 32'h111111);
        for (int i = 0; i < 6; i++)
            cyc(0, 1, 1, 0, 32'h0f, 32'h123456);
        for (int i = 0; i < 3; i++)
            cyc(0, 1, 0, 0, 32'hf0, 32'hfedcba);
        for (int i = 0; i < 12; i++)
            cyc(0, 1, 1, 0, 32'h0f, 32'h123456);

        // Reset mid-dwell at A ptr=5.
        cyc(1, 1, 1, 0, 32'h3c, 32'h777777);
        for (int i = 0; i < 11; i++)
            cyc(0, 1, 1, 0, 32'h3c, 32'h123456);
        cyc(1, 1, 1, 0, 32'hff, 32'hffffff);
        for (int i = 0; i < 8; i++)
            cyc(0, 1, 1, 0, 32'h3d, 32'h123456);

        // One manual cycle at A ptr=4, then auto restarts at channel 0.
        cyc(1, 1, 1, 0, 32'h00, 32'h000000);
        for (int i = 0; i < 8; i++)
            cyc(0, 1, 1, 0, 32'h52, 32'h0fedcb);
        cyc(0, 0, 1, 1, 32'h52, 32'h0fedcb);
        for (int i = 0; i < 10; i++)
            cyc(0, 1, 1, 0, 32'h53, 32'h0fedcb);

        // Randomized mix.
        for (int i = 0; i < 400; i++) begin
            rb = $urandom;
            cyc(rb[5:0] == 6'd0, rb[9:8] != 2'b00, rb[12:10] != 3'b000,
                int'(rb[15:13]), $urandom, $urandom);
        end

        @(negedge clk);
        @(negedge clk);
        chk("a_drain", qa.size(), 0);
        chk("b_drain", qb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
